// File: rtl/alu_operand_issue.sv
// Decode/issue stage ahead of the EX-stage ALU: turns an instruction plus register
// values into ALU operands/control and buffers them in a 2-entry skid queue.
module alu_operand_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [5:0]      aluc,
  output logic [4:0]      dest,
  output logic            illegal
);

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;
  localparam logic [5:0] ALU_JR   = 6'b001000;
  localparam logic [5:0] ALU_LUI  = 6'b001111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [5:0]      aluc;
    logic [4:0]      dest;
    logic            illegal;
  } entry_t;

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  entry_t dec;

  // Undecodable encodings fall through to the defaults: ADDU of zeros, no writeback.
  always_comb begin
    dec.a       = '0;
    dec.b       = '0;
    dec.aluc    = ALU_ADDU;
    dec.dest    = '0;
    dec.illegal = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: begin
            dec.aluc = funct;
            dec.a    = rs_val;
            dec.b    = rt_val;
            dec.dest = rd;
          end
          6'h00, 6'h02, 6'h03: begin
            dec.aluc = funct;
            dec.a    = {{(XLEN-5){1'b0}}, shamt};
            dec.b    = rt_val;
            dec.dest = rd;
          end
          6'h08: begin
            dec.aluc = ALU_JR;
            dec.a    = rs_val;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        case (op[1:0])
          2'b00:   dec.aluc = ALU_ADD;
          2'b01:   dec.aluc = ALU_ADDU;
          2'b10:   dec.aluc = ALU_SLT;
          default: dec.aluc = ALU_SLTU;
        endcase
        dec.a    = rs_val;
        dec.b    = {{(XLEN-16){imm[15]}}, imm};
        dec.dest = rt;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        case (op[1:0])
          2'b00:   dec.aluc = ALU_AND;
          2'b01:   dec.aluc = ALU_OR;
          default: dec.aluc = ALU_XOR;
        endcase
        dec.a    = rs_val;
        dec.b    = {{(XLEN-16){1'b0}}, imm};
        dec.dest = rt;
      end
      6'h0F: begin
        dec.aluc = ALU_LUI;
        dec.b    = {{(XLEN-16){1'b0}}, imm};
        dec.dest = rt;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  entry_t      slot0;
  entry_t      slot1;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  entry_t      head;

  assign in_ready  = (count < 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // slot0 is always the head; a simultaneous push/pop can only happen at count=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= dec;
          else               slot1 <= dec;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: slot0 <= dec;
        default: ;
      endcase
    end
  end

  assign head    = out_valid ? slot0 : '0;
  assign a       = head.a;
  assign b       = head.b;
  assign aluc    = head.aluc;
  assign dest    = head.dest;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: decode vectors, backpressure, flush, async reset.
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  aluc;
  logic [4:0]  dest;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_operand_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .aluc(aluc), .dest(dest), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    instr    = i;
    rs_val   = rs;
    rt_val   = rt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [5:0] ealuc, input logic [4:0] edest, input logic eill);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".a"},     a, ea);
    check({tag, ".b"},     b, eb);
    check({tag, ".aluc"},  {26'b0, aluc}, {26'b0, ealuc});
    check({tag, ".dest"},  {27'b0, dest}, {27'b0, edest});
    check({tag, ".ill"},   {31'b0, illegal}, {31'b0, eill});
  endtask

  initial begin
    #12;
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.ready", {31'b0, in_ready}, 32'd1);
    check("rst.aluc",  {26'b0, aluc}, 32'd0);
    rst_n = 1'b1;
    step();

    push_one(32'h00221820, 32'h0000001C, 32'h00000021);
    check_head("add", 32'h0000001C, 32'h00000021, 6'b100000, 5'd3, 1'b0);
    pop_one();
    check("add.empty", {31'b0, out_valid}, 32'd0);
    check("add.zero_a", a, 32'd0);

    push_one(32'h00021140, 32'h12345678, 32'h00000021);
    check_head("sll", 32'h00000005, 32'h00000021, 6'b000000, 5'd2, 1'b0);
    pop_one();

    push_one(32'h2022FFFF, 32'h00000010, 32'hDEADBEEF);
    check_head("addi", 32'h00000010, 32'hFFFFFFFF, 6'b100000, 5'd2, 1'b0);
    pop_one();
    push_one(32'h3422FFFF, 32'h00000010, 32'hDEADBEEF);
    check_head("ori", 32'h00000010, 32'h0000FFFF, 6'b100101, 5'd2, 1'b0);
    pop_one();
    push_one(32'h3C011234, 32'h00000010, 32'hDEADBEEF);
    check_head("lui", 32'h00000000, 32'h00001234, 6'b001111, 5'd1, 1'b0);
    pop_one();
    push_one(32'h03E00008, 32'h00400000, 32'h00000007);
    check_head("jr", 32'h00400000, 32'h00000000, 6'b001000, 5'd0, 1'b0);
    pop_one();
    push_one(32'h2C438000, 32'h00000005, 32'h0);
    check_head("sltiu", 32'h00000005, 32'hFFFF8000, 6'b101011, 5'd3, 1'b0);
    pop_one();

    // Backpressure: three offers against a stalled consumer.
    instr = 32'h00221820; rt_val = 32'h0; rs_val = 32'h11; in_valid = 1'b1;
    step();
    check("bp1.ready", {31'b0, in_ready}, 32'd1);
    rs_val = 32'h22;
    step();
    check("bp2.ready", {31'b0, in_ready}, 32'd0);
    check("bp2.head",  a, 32'h11);
    rs_val = 32'h33;
    step();
    check("bp3.ready", {31'b0, in_ready}, 32'd0);
    check("bp3.held",  a, 32'h11);
    check("bp3.valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp4.head",  a, 32'h22);
    check("bp4.ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp5.head",  a, 32'h33);
    check("bp5.valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp6.empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Flush at count=2 with a push offered.
    push_one(32'h00221820, 32'h1, 32'h2);
    push_one(32'h00221820, 32'h3, 32'h4);
    check("fl.full", {31'b0, in_ready}, 32'd0);
    instr = 32'h00221820; rs_val = 32'h5; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.valid", {31'b0, out_valid}, 32'd0);
    check("fl.ready", {31'b0, in_ready}, 32'd1);
    step();
    check("fl.lost", {31'b0, out_valid}, 32'd0);

    push_one(32'hFC000000, 32'hAAAA5555, 32'h5555AAAA);
    check_head("illegal", 32'h0, 32'h0, 6'b100001, 5'd0, 1'b1);
    pop_one();

    // Async reset with one entry queued, away from the clock edge.
    push_one(32'h00221820, 32'h0000001C, 32'h00000021);
    check("ar.pre", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.valid", {31'b0, out_valid}, 32'd0);
    check("ar.ready", {31'b0, in_ready}, 32'd1);
    check("ar.a",     a, 32'd0);
    check("ar.b",     b, 32'd0);
    check("ar.aluc",  {26'b0, aluc}, 32'd0);
    check("ar.dest",  {27'b0, dest}, 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("ar.after", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
